int_mul_pipe: RTL and testbench

- Pipelined RV64M multiply execution unit in stage 3.
- Accepts issued MUL/MULH/MULHSU/MULHU/MULW operations with a valid/ready handshake.
- Converts signed operands to magnitudes and drives the existing unsigned combinational core `int_mul`.
- Sign-corrects the 2·XLEN-bit product, selects the RISC-V result, and holds it with its tag until the writeback/CDB arbiter accepts it.

---
 rtl/fu_pkg.sv | 34 +++
 rtl/int_mul.sv | 14 +
 rtl/mul_operand_cond.sv | 42 ++++
 rtl/int_mul_pipe.sv | 138 +++++++++++++
 tb/tb_int_mul_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fu_pkg.sv
// Shared types for the integer functional units: multiply opcode and the
// S1 payload carried between operand conditioning and product fix-up.
package fu_pkg;

  localparam int unsigned FU_XLEN  = 64;
  localparam int unsigned FU_TAG_W = 6;
  localparam int unsigned FU_WLEN  = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } mul_op_e;

  typedef struct packed {
    logic [FU_XLEN-1:0]  mag_a;
    logic [FU_XLEN-1:0]  mag_b;
    logic                neg;
    mul_op_e             op;
    logic                word;
    logic [FU_TAG_W-1:0] tag;
  } mul_s1_t;

  // rs1 is signed for MUL/MULH/MULHSU; rs2 only for MUL/MULH
  function automatic logic op_a_signed(input mul_op_e op);
    return op != OP_MULHU;
  endfunction

  function automatic logic op_b_signed(input mul_op_e op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/int_mul.sv
// Unsigned combinational N x N -> 2N multiplier core.
module int_mul #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] prod_c_o
);

  localparam int unsigned PW = 2 * N;

  assign prod_c_o = PW'(a_i) * PW'(b_i);

endmodule

// File: rtl/mul_operand_cond.sv
// Operand conditioning for the multiplier: W-form sign extension, signed
// operands turned into magnitudes, and the sign of the final product.
module mul_operand_cond
  import fu_pkg::*;
#(
  parameter int unsigned XLEN = FU_XLEN
) (
  input  mul_op_e          op_i,
  input  logic             word_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  output mul_op_e          op_c_o,
  output logic [XLEN-1:0]  mag_a_c_o,
  output logic [XLEN-1:0]  mag_b_c_o,
  output logic             neg_c_o
);

  localparam int unsigned WW = FU_WLEN;

  logic [XLEN-1:0] a_eff;
  logic [XLEN-1:0] b_eff;
  logic            a_neg;
  logic            b_neg;

  always_comb begin
    a_eff  = a_i;
    b_eff  = b_i;
    op_c_o = op_i;
    if (word_i) begin
      a_eff  = {{(XLEN-WW){a_i[WW-1]}}, a_i[WW-1:0]};
      b_eff  = {{(XLEN-WW){b_i[WW-1]}}, b_i[WW-1:0]};
      op_c_o = OP_MUL;
    end
    a_neg = op_a_signed(op_c_o) & a_eff[XLEN-1];
    b_neg = op_b_signed(op_c_o) & b_eff[XLEN-1];
    // -2^(XLEN-1) negates to itself, which is the correct unsigned magnitude
    mag_a_c_o = a_neg ? (~a_eff + XLEN'(1)) : a_eff;
    mag_b_c_o = b_neg ? (~b_eff + XLEN'(1)) : b_eff;
    neg_c_o   = a_neg ^ b_neg;
  end

endmodule

// File: rtl/int_mul_pipe.sv
// Two-stage RV64M multiply unit: S1 holds conditioned magnitudes, S2 holds
// the sign-corrected, selected result until the writeback arbiter takes it.
module int_mul_pipe
  import fu_pkg::*;
#(
  parameter int unsigned XLEN  = FU_XLEN,
  parameter int unsigned TAG_W = FU_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  mul_op_e          in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned WW = FU_WLEN;

  logic             s1_valid_q, s1_valid_d;
  mul_s1_t          s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             s1_load;
  logic             s2_load;
  mul_op_e          cond_op;
  logic [XLEN-1:0]  cond_mag_a;
  logic [XLEN-1:0]  cond_mag_b;
  logic             cond_neg;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_fix;
  logic [XLEN-1:0]  res_sel;

  mul_operand_cond #(
    .XLEN (XLEN)
  ) u_cond (
    .op_i      (in_op),
    .word_i    (in_word),
    .a_i       (in_a),
    .b_i       (in_b),
    .op_c_o    (cond_op),
    .mag_a_c_o (cond_mag_a),
    .mag_b_c_o (cond_mag_b),
    .neg_c_o   (cond_neg)
  );

  int_mul #(
    .N (XLEN)
  ) u_int_mul (
    .a_i      (s1_q.mag_a),
    .b_i      (s1_q.mag_b),
    .prod_c_o (prod)
  );

  // Handshake: S2 drains and S1 advances on the same edge, so no bubbles
  always_comb begin
    s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !flush && (!s1_valid_q || s2_load);
    s1_load  = in_valid && in_ready;
  end

  // Sign fix-up across the full product, then RISC-V result selection
  always_comb begin
    prod_fix = s1_q.neg ? (~prod + PW'(1)) : prod;
    if (s1_q.word) begin
      res_sel = {{(XLEN-WW){prod_fix[WW-1]}}, prod_fix[WW-1:0]};
    end else if (s1_q.op == OP_MUL) begin
      res_sel = prod_fix[XLEN-1:0];
    end else begin
      res_sel = prod_fix[PW-1:XLEN];
    end
  end

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    tag_d      = tag_q;

    if (s1_load) begin
      s1_d.mag_a = cond_mag_a;
      s1_d.mag_b = cond_mag_b;
      s1_d.neg   = cond_neg;
      s1_d.op    = cond_op;
      s1_d.word  = in_word;
      s1_d.tag   = in_tag;
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      res_d      = res_sel;
      tag_d      = s1_q.tag;
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    // A completion in the flush cycle still counts; only the valids die
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      tag_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      tag_q      <= tag_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = res_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_int_mul_pipe.sv
// Directed bench for int_mul_pipe: opcode results, latency, stall/back-pressure,
// flush and asynchronous reset behaviour.
module tb_int_mul_pipe;
  import fu_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  mul_op_e     in_op;
  logic        in_word;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [5:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [5:0]  out_tag;

  int tests_run;
  int tests_failed;

  int_mul_pipe #(
    .XLEN  (64),
    .TAG_W (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_word    (in_word),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_op(input mul_op_e op, input logic word, input logic [63:0] a,
                          input logic [63:0] b, input logic [5:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_word  = word;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  // Issue one op with out_ready high; lat counts edges from drive to out_valid
  task automatic run_one(input mul_op_e op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input logic [5:0] tag,
                         output logic [63:0] res, output logic [5:0] otag,
                         output int lat, output logic acc);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_op(op, word, a, b, tag);
    @(negedge clk);
    acc = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    res = 'x;
    otag = 'x;
    while (lat < 10) begin
      @(negedge clk);
      if (out_valid) begin
        res  = out_result;
        otag = out_tag;
        break;
      end
      @(posedge clk);
      lat++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = OP_MUL; in_word = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_result !== 64'h0 || out_tag !== 6'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b result=%h tag=%h, want 0/0/0",
               out_valid, out_result, out_tag);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_mul();
    logic [63:0] res; logic [5:0] otag; int lat; logic acc;
    run_one(OP_MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 6'h15, res, otag, lat, acc);
    tests_run++;
    if (acc !== 1'b1) begin
      tests_failed++; $display("FAIL mul_accept: in_ready got %b, want 1", acc);
    end
    tests_run++;
    if (lat !== 2) begin
      tests_failed++; $display("FAIL mul_latency: got %0d, want 2", lat);
    end
    tests_run++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      tests_failed++; $display("FAIL mul_result: got %h, want fffffffffffffff1", res);
    end
    tests_run++;
    if (otag !== 6'h15) begin
      tests_failed++; $display("FAIL mul_tag: got %h, want 15", otag);
    end
  endtask

  task automatic test_mulh();
    logic [63:0] res; logic [5:0] otag; int lat; logic acc;
    run_one(OP_MULH, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'h01,
            res, otag, lat, acc);
    tests_run++;
    if (res !== 64'h4000_0000_0000_0000) begin
      tests_failed++; $display("FAIL mulh_min: got %h, want 4000000000000000", res);
    end
    run_one(OP_MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'h02,
            res, otag, lat, acc);
    tests_run++;
    if (res !== 64'h0) begin
      tests_failed++; $display("FAIL mulh_m1: got %h, want 0", res);
    end
  endtask

  task automatic test_mulhsu_mulhu();
    logic [63:0] res; logic [5:0] otag; int lat; logic acc;
    run_one(OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'h03,
            res, otag, lat, acc);
    tests_run++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      tests_failed++; $display("FAIL mulhsu: got %h, want ffffffffffffffff", res);
    end
    run_one(OP_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'h04,
            res, otag, lat, acc);
    tests_run++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      tests_failed++; $display("FAIL mulhu: got %h, want fffffffffffffffe", res);
    end
  endtask

  task automatic test_mulw();
    logic [63:0] res; logic [5:0] otag; int lat; logic acc;
    run_one(OP_MUL, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 6'h05, res, otag, lat, acc);
    tests_run++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      tests_failed++; $display("FAIL mulw_sext: got %h, want fffffffffffffffe", res);
    end
    run_one(OP_MUL, 1'b1, 64'hDEAD_0000_0000_0003, 64'd4, 6'h06, res, otag, lat, acc);
    tests_run++;
    if (res !== 64'h0000_0000_0000_000C) begin
      tests_failed++; $display("FAIL mulw_upper_ignored: got %h, want 000000000000000c", res);
    end
    // W-form with a non-MUL opcode still behaves as MULW
    run_one(OP_MULHU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd3, 6'h07, res, otag, lat, acc);
    tests_run++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      tests_failed++; $display("FAIL mulw_op_override: got %h, want fffffffffffffffd", res);
    end
  endtask

  task automatic test_back_to_back();
    mul_op_e     ops [4];
    logic [63:0] av  [4];
    logic [63:0] bv  [4];
    logic [63:0] ev  [4];
    logic [5:0]  tg  [4];
    int          sent, recv;
    logic [63:0] prev_res;
    logic [5:0]  prev_tag;
    logic        prev_stall;
    logic        exp_rdy;
    ops[0] = OP_MUL;   av[0] = 64'd2; bv[0] = 64'd3;                 ev[0] = 64'd6;                  tg[0] = 6'h11;
    ops[1] = OP_MUL;   av[1] = 64'd4; bv[1] = 64'd5;                 ev[1] = 64'd20;                 tg[1] = 6'h12;
    ops[2] = OP_MUL;   av[2] = 64'd7; bv[2] = 64'hFFFF_FFFF_FFFF_FFFF; ev[2] = 64'hFFFF_FFFF_FFFF_FFF9; tg[2] = 6'h13;
    ops[3] = OP_MULHU; av[3] = 64'hFFFF_FFFF_FFFF_FFFF; bv[3] = 64'd2; ev[3] = 64'd1;                tg[3] = 6'h14;
    sent = 0; recv = 0; prev_stall = 1'b0; prev_res = '0; prev_tag = '0;
    for (int c = 0; c < 40 && recv < 4; c++) begin
      @(posedge clk); #1;
      out_ready = (c >= 5);
      if (sent < 4) drive_op(ops[sent], 1'b0, av[sent], bv[sent], tg[sent]);
      else in_valid = 1'b0;
      @(negedge clk);
      if (c < 5) begin
        exp_rdy = (c < 2);
        tests_run++;
        if (in_ready !== exp_rdy) begin
          tests_failed++;
          $display("FAIL b2b_in_ready cycle %0d: got %b, want %b", c, in_ready, exp_rdy);
        end
      end
      if (out_valid && !out_ready) begin
        if (prev_stall) begin
          tests_run++;
          if (out_result !== prev_res || out_tag !== prev_tag) begin
            tests_failed++;
            $display("FAIL b2b_stall_stable cycle %0d: got %h/%h, want %h/%h",
                     c, out_result, out_tag, prev_res, prev_tag);
          end
        end
        prev_res = out_result; prev_tag = out_tag; prev_stall = 1'b1;
      end
      if (out_valid && out_ready) begin
        tests_run++;
        if (out_result !== ev[recv] || out_tag !== tg[recv]) begin
          tests_failed++;
          $display("FAIL b2b_result %0d: got %h tag %h, want %h tag %h",
                   recv, out_result, out_tag, ev[recv], tg[recv]);
        end
        recv++;
        prev_stall = 1'b0;
      end
      if (in_valid && in_ready) sent++;
    end
    tests_run++;
    if (recv !== 4) begin
      tests_failed++; $display("FAIL b2b_count: got %0d results, want 4", recv);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL b2b_no_dup cycle %0d: out_valid got %b, want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_op(OP_MUL, 1'b0, 64'd9, 64'd9, 6'h21);
    @(posedge clk); #1;
    drive_op(OP_MUL, 1'b0, 64'd8, 64'd8, 6'h22);
    @(posedge clk); #1;
    flush = 1'b1;
    drive_op(OP_MUL, 1'b0, 64'd7, 64'd7, 6'h23);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_cycle: in_ready=%b out_valid=%b, want 0/1", in_ready, out_valid);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_cleared: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL flush_dropped_input cycle %0d: out_valid got %b, want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_op(OP_MUL, 1'b0, 64'd5, 64'd6, 6'h31);
    @(posedge clk); #1;
    drive_op(OP_MUL, 1'b0, 64'd7, 64'd8, 6'h32);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_result !== 64'd30 || out_tag !== 6'h31) begin
      tests_failed++;
      $display("FAIL rstmid_prefill: got %b/%h/%h, want 1/1e/31", out_valid, out_result, out_tag);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_result !== 64'h0 || out_tag !== 6'h0) begin
      tests_failed++;
      $display("FAIL rstmid_async: got %b/%h/%h, want 0/0/0", out_valid, out_result, out_tag);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL rstmid_stale cycle %0d: out_valid got %b, want 0", c, out_valid);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_mul();
    test_mulh();
    test_mulhsu_mulhu();
    test_mulw();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
